tok_fifol0_rr_sched: RTL and testbench

Round-robin enqueue scheduler for a shared, data-less "loopy" token FIFO: up to p3nreq producers compete for slots, and one consumer dequeues. Each granted request enqueues one token and records the winning requester's index. The consumer therefore sees both occupancy (EMPTY_N/FULL_N/COUNT) and the owner of the head token (HEAD_ID). It sits between the producer agents and the shared resource, in place of a bare counted FIFO, wherever credits must be fairly shared and returned to their owner.

---
 rtl/tok_fifol0_rr_sched.sv | 137 +++++++++++++
 tb/tb_tok_fifol0_rr_sched.sv | 139 +++++++++++++
 2 files changed

// File: rtl/tok_fifol0_rr_sched.sv
// tok_fifol0_rr_sched
//   Round-robin enqueue scheduler in front of a data-less token FIFO. Each cycle
//   at most one requester is granted. Its index is stored as the owner of the
//   token it enqueues, so the consumer can see who owns the head token.
//   Loopy behaviour: a slot freed by this cycle's dequeue can be refilled in
//   the same cycle, so one enqueue plus one dequeue per cycle is sustained at full.
//
// Ports
//   CLK      in   clock, all state updates on posedge
//   RST_N    in   synchronous active-low reset
//   CLR      in   synchronous clear (empties FIFO, resets round-robin pointer)
//   REQ      in   [p3nreq]  per-requester enqueue request
//   GNT      out  [p3nreq]  one-hot grant, combinational
//   DEQ      in   consumer dequeue of the head token
//   EMPTY_N  out  registered, 1 when COUNT > 0
//   FULL_N   out  not_full OR DEQ
//   HEAD_ID  out  [p4idw]   owner index of the head token, 0 when empty
//   COUNT    out  [p2cntr_width] registered occupancy
module tok_fifol0_rr_sched #(
   parameter int unsigned p1depth      = 4,
   parameter int unsigned p2cntr_width = 3,
   parameter int unsigned p3nreq       = 4,
   parameter int unsigned p4idw        = 2
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    CLR,
   input  logic [p3nreq-1:0]       REQ,
   output logic [p3nreq-1:0]       GNT,
   input  logic                    DEQ,
   output logic                    EMPTY_N,
   output logic                    FULL_N,
   output logic [p4idw-1:0]        HEAD_ID,
   output logic [p2cntr_width-1:0] COUNT
);

   localparam int unsigned PW = (p1depth > 1) ? $clog2(p1depth) : 1;
   // One extra bit so rr_ptr + offset never overflows before the wrap test.
   localparam int unsigned CW = p4idw + 1;

   logic                    r_not_full;
   logic                    r_not_empty;
   logic [p2cntr_width-1:0] r_count;
   logic [p4idw-1:0]        r_id [p1depth];
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic [p4idw-1:0]        r_rr_ptr;

   logic                    w_space;
   logic                    w_enq;
   logic                    w_deq;
   logic [p4idw-1:0]        w_gnt_idx;
   logic [p3nreq-1:0]       w_gnt;
   logic [CW-1:0]           w_cand;
   logic [PW-1:0]           w_wr_nxt;
   logic [PW-1:0]           w_rd_nxt;

   assign w_space = r_not_full | (DEQ & r_not_empty);

   // Search from rr_ptr upward with wrap; the first set request wins.
   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_enq     = 1'b0;
      w_cand    = '0;
      if (RST_N && !CLR && w_space) begin
         for (int i = 0; i < int'(p3nreq); i++) begin
            w_cand = CW'(r_rr_ptr) + CW'(i);
            if (w_cand >= CW'(p3nreq)) begin
               w_cand = w_cand - CW'(p3nreq);
            end
            if (!w_enq && REQ[w_cand[p4idw-1:0]]) begin
               w_enq     = 1'b1;
               w_gnt_idx = w_cand[p4idw-1:0];
               w_gnt[w_cand[p4idw-1:0]] = 1'b1;
            end
         end
      end
   end

   // A dequeue while empty is dropped here; an enqueue into an empty FIFO
   // is never bypassed to the consumer.
   assign w_deq = DEQ & r_not_empty & RST_N & ~CLR;

   assign w_wr_nxt = (r_wr_ptr == PW'(p1depth - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_nxt = (r_rd_ptr == PW'(p1depth - 1)) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         r_not_full  <= 1'b1;
         r_not_empty <= 1'b0;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= w_wr_nxt;
            r_rr_ptr <= (w_gnt_idx == p4idw'(p3nreq - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
         if (w_deq) begin
            r_rd_ptr <= w_rd_nxt;
         end
         if (w_enq && !w_deq) begin
            r_count     <= r_count + 1'b1;
            r_not_empty <= 1'b1;
            r_not_full  <= (r_count != p2cntr_width'(p1depth - 1));
         end else if (w_deq && !w_enq) begin
            r_count     <= r_count - 1'b1;
            r_not_full  <= 1'b1;
            r_not_empty <= (r_count != p2cntr_width'(1));
         end
      end
   end

   // Owner array needs no reset: HEAD_ID is masked while empty.
   always_ff @(posedge CLK) begin
      if (w_enq) begin
         r_id[r_wr_ptr] <= w_gnt_idx;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (RST_N && !CLR && DEQ && !r_not_empty) begin
         $warning("tok_fifol0_rr_sched: DEQ while empty ignored");
      end
   end
`endif

   assign GNT     = w_gnt;
   assign EMPTY_N = r_not_empty;
   assign FULL_N  = r_not_full | DEQ;
   assign HEAD_ID = r_not_empty ? r_id[r_rd_ptr] : '0;
   assign COUNT   = r_count;

endmodule

// File: tb/tb_tok_fifol0_rr_sched.sv
// Testbench for tok_fifol0_rr_sched: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_tok_fifol0_rr_sched;

   localparam int DEPTH = 4;
   localparam int CNTW  = 3;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic            CLR;
   logic [NREQ-1:0] REQ;
   logic [NREQ-1:0] GNT;
   logic            DEQ;
   logic            EMPTY_N;
   logic            FULL_N;
   logic [IDW-1:0]  HEAD_ID;
   logic [CNTW-1:0] COUNT;

   tok_fifol0_rr_sched #(
      .p1depth      (DEPTH),
      .p2cntr_width (CNTW),
      .p3nreq       (NREQ),
      .p4idw        (IDW)
   ) u_dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .CLR     (CLR),
      .REQ     (REQ),
      .GNT     (GNT),
      .DEQ     (DEQ),
      .EMPTY_N (EMPTY_N),
      .FULL_N  (FULL_N),
      .HEAD_ID (HEAD_ID),
      .COUNT   (COUNT)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference model: owner queue (front = head) and next-priority index.
   int m_q[$];
   int m_rr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] req);
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (m_rr + k) % NREQ;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   // One clock cycle: drive, check outputs against the model, then advance it.
   task automatic step(input logic rst, input logic clr, input logic [NREQ-1:0] req,
                       input logic deq);
      int              w;
      int              sz;
      logic [NREQ-1:0] eg;
      @(negedge CLK);
      RST_N = ~rst;
      CLR   = clr;
      REQ   = req;
      DEQ   = deq;
      #1;
      sz = m_q.size();
      w  = -1;
      if (!rst && !clr && ((sz < DEPTH) || (deq && sz > 0))) w = pick(req);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      check("gnt",     32'(GNT),     32'(eg));
      check("full_n",  32'(FULL_N),  32'((sz < DEPTH) || deq));
      check("empty_n", 32'(EMPTY_N), 32'(sz > 0));
      check("count",   32'(COUNT),   32'(sz));
      check("head_id", 32'(HEAD_ID), 32'((sz > 0) ? m_q[0] : 0));
      @(posedge CLK);
      if (rst || clr) begin
         m_q.delete();
         m_rr = 0;
      end else begin
         if (deq && sz > 0) void'(m_q.pop_front());
         if (w >= 0) begin
            m_q.push_back(w);
            m_rr = (w + 1) % NREQ;
         end
      end
   endtask

   initial begin
      RST_N = 1'b0;
      CLR   = 1'b0;
      REQ   = '0;
      DEQ   = 1'b0;
      repeat (2) @(posedge CLK);

      // Fill from all requesters: grants 0,1,2,3 then none.
      repeat (4) step(1'b0, 1'b0, 4'b1111, 1'b0);
      step(1'b0, 1'b0, 4'b1111, 1'b0);
      // Loopy at full: requester 2 refills as heads drain.
      repeat (3) step(1'b0, 1'b0, 4'b0100, 1'b1);
      // Drain.
      repeat (4) step(1'b0, 1'b0, 4'b0000, 1'b1);
      // Enqueue into empty with DEQ: no bypass.
      step(1'b0, 1'b0, 4'b0010, 1'b1);
      step(1'b0, 1'b0, 4'b0000, 1'b0);
      // rr_ptr=2: 0011 wraps to 0 then 1; then 1001 picks 3 before 0.
      repeat (2) step(1'b0, 1'b0, 4'b0011, 1'b0);
      repeat (2) step(1'b0, 1'b0, 4'b1001, 1'b1);
      // Clear with requests and dequeue asserted, then restart at 0.
      step(1'b0, 1'b1, 4'b1111, 1'b1);
      repeat (2) step(1'b0, 1'b0, 4'b1111, 1'b0);
      // Reset mid-operation with requests active.
      step(1'b1, 1'b0, 4'b1111, 1'b0);
      repeat (2) step(1'b0, 1'b0, 4'b1111, 1'b0);

      // Random traffic.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] r;
         r = $urandom;
         step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
              r[NREQ-1:0], $urandom_range(0, 2) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
